// File: rtl/flaf_pkg.sv
// rtl/flaf_pkg.sv - shared constants, FSM encoding and helpers for the FLAF datapath
package flaf_pkg;

    localparam int FLAF_Q_ORD  = 7;
    localparam int FLAF_WIDTH  = 16;
    localparam int FLAF_QP_PHI = 15;
    localparam int FLAF_QP_W   = 12;
    localparam int FLAF_QP_OUT = 12;

    function automatic int acc_w_f(input int width, input int q_ord);
        return 2 * width + $clog2(q_ord);
    endfunction

    function automatic int sh_f(input int qp_phi, input int qp_w, input int qp_out);
        return qp_phi + qp_w - qp_out;
    endfunction

    localparam int FLAF_ACC_W = acc_w_f(FLAF_WIDTH, FLAF_Q_ORD);
    localparam int FLAF_SH    = sh_f(FLAF_QP_PHI, FLAF_QP_W, FLAF_QP_OUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // LSB position of element idx inside a packed vector of width-bit words
    function automatic int elem_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/flaf_round_sat.sv
// rtl/flaf_round_sat.sv - round-half-up and saturate a wide accumulator to WIDTH bits
module flaf_round_sat #(
    parameter int ACC_W = 35,
    parameter int SH    = 15,
    parameter int WIDTH = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [WIDTH-1:0] y
);

    // One guard bit so adding the half-LSB can never wrap the accumulator
    localparam logic signed [ACC_W:0] HALF  = {{(ACC_W-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        sum     = {acc[ACC_W-1], acc} + HALF;
        shifted = sum >>> SH;
        y       = shifted[WIDTH-1:0];
        if (shifted > MAX_V) begin
            y = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            y = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

endmodule

// File: rtl/flaf_phi_weight_mac.sv
// rtl/flaf_phi_weight_mac.sv - time-multiplexed y = sum(w[i]*phi[i]) with rounded, saturated output
module flaf_phi_weight_mac
    import flaf_pkg::*;
#(
    parameter int Q_ORD  = FLAF_Q_ORD,
    parameter int WIDTH  = FLAF_WIDTH,
    parameter int QP_PHI = FLAF_QP_PHI,
    parameter int QP_W   = FLAF_QP_W,
    parameter int QP_OUT = FLAF_QP_OUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [Q_ORD*WIDTH-1:0]   phi_in_packed,
    input  logic [Q_ORD*WIDTH-1:0]   w_in_packed,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         y_out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int ACC_W = acc_w_f(WIDTH, Q_ORD);
    localparam int SH    = sh_f(QP_PHI, QP_W, QP_OUT);
    localparam int IDX_W = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Q_ORD - 1);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] phi_q [Q_ORD];
    logic signed [WIDTH-1:0] phi_d [Q_ORD];
    logic signed [WIDTH-1:0] w_q   [Q_ORD];
    logic signed [WIDTH-1:0] w_d   [Q_ORD];
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [IDX_W-1:0] idx_q, idx_d;
    logic        [WIDTH-1:0] y_q, y_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic        [WIDTH-1:0]   y_rs;

    always_comb begin
        prod     = w_q[idx_q] * phi_q[idx_q];
        prod_ext = ACC_W'(prod);
        acc_sum  = acc_q + prod_ext;
    end

    // Rounds the sum including the final product, so y is ready on the last MAC edge
    flaf_round_sat #(
        .ACC_W (ACC_W),
        .SH    (SH),
        .WIDTH (WIDTH)
    ) u_round_sat (
        .acc (acc_sum),
        .y   (y_rs)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        phi_d   = phi_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < Q_ORD; i++) begin
                        phi_d[i] = phi_in_packed[elem_lsb(i, WIDTH) +: WIDTH];
                        w_d[i]   = w_in_packed[elem_lsb(i, WIDTH) +: WIDTH];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    y_d     = y_rs;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
        end
    end

    // Operand arrays are only consumed after an accept, so they carry no reset
    always_ff @(posedge clk) begin
        phi_q <= phi_d;
        w_q   <= w_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign y_out     = y_q;

endmodule

// File: tb/tb_flaf_phi_weight_mac.sv
// tb/tb_flaf_phi_weight_mac.sv - directed self-checking bench for flaf_phi_weight_mac
module tb_flaf_phi_weight_mac;

    logic         clk = 1'b0;
    logic         reset;
    logic [111:0] phi_in_packed;
    logic [111:0] w_in_packed;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  y_out;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    flaf_phi_weight_mac dut (
        .clk           (clk),
        .reset         (reset),
        .phi_in_packed (phi_in_packed),
        .w_in_packed   (w_in_packed),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .y_out         (y_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < 7; i++) begin
            phi_in_packed[16*i +: 16] = 16'($urandom);
            w_in_packed[16*i +: 16]   = 16'($urandom);
        end
    endtask

    task automatic run(input string tag, input logic [111:0] pv, input logic [111:0] wv,
                       input logic [15:0] exp_y);
        int cyc;
        @(negedge clk);
        chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        phi_in_packed = pv;
        w_in_packed   = wv;
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        chk({tag, "_y"}, 32'(y_out), 32'(exp_y));
        @(negedge clk);
        chk({tag, "_in_ready_post"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_post"}, 32'(out_valid), 32'd0);
    endtask

    logic [111:0] pv;
    logic [111:0] wv;
    int           cyc;
    int           stale;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        scramble();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        reset = 1'b0;

        run("nominal", {7{16'h4000}}, {7{16'h1000}}, 16'h3800);
        run("round_up", {96'h0, 16'h0001}, {96'h0, 16'h4000}, 16'h0001);
        run("round_down", {96'h0, 16'h0001}, {96'h0, 16'h3FFF}, 16'h0000);
        run("neg_tie", {96'h0, 16'hFFFF}, {96'h0, 16'h4000}, 16'h0000);
        run("neg_below", {96'h0, 16'hFFFF}, {96'h0, 16'h4001}, 16'hFFFF);
        run("sat_pos", {7{16'h7FFF}}, {7{16'h7FFF}}, 16'h7FFF);
        run("sat_neg", {7{16'h7FFF}}, {7{16'h8000}}, 16'h8000);
        for (int i = 0; i < 7; i++) pv[16*i +: 16] = (i % 2 == 0) ? 16'h4000 : 16'hC000;
        run("mixed", pv, {7{16'h1000}}, 16'h0800);

        out_ready = 1'b0;
        @(negedge clk);
        phi_in_packed = {7{16'h4000}};
        w_in_packed   = {7{16'h1000}};
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd8);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_y", 32'(y_out), 32'h3800);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            scramble();
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_hold_last", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);

        phi_in_packed = {7{16'h7FFF}};
        w_in_packed   = {7{16'h7FFF}};
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(y_out), 32'd0);
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mid_rst_no_stale", 32'(stale), 32'd0);
        run("after_rst", {96'h0, 16'h0001}, {96'h0, 16'h4000}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
